z80_pin_mux: RTL
================

# z80_pin_mux

Parametrised bus-to-pin multiplexer between the Z80 core and the 8-bit dedicated output pins of the Tiny Tapeout wrapper. On each accepted bus strobe it captures the core's address and control signals as one frame and emits it over `PIN_W` pins as `NPH` consecutive slots. A ready/valid handshake lets frames run back-to-back, and a sticky overrun flag reports strobes dropped while the block was busy. It generalises the fixed address/control multiplexing of the current top level to arbitrary address, control and pin widths.

## Interface
Parameters:
- `ADDR_W`, default 16, address bits per frame.
- `CTRL_W`, default 8, control bits per frame (M1, MREQ, IORQ, RD, WR, RFSH, HALT, BUSAK at default).
- `PIN_W`, default 8, output pin width.
- Derived `NPH = ceil((ADDR_W+CTRL_W)/PIN_W)`, default 3. Derived `PH_W = max(1, clog2(NPH))`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `bus_valid` in 1: core presents a new bus state this cycle.
- `addr_in` in ADDR_W: address to capture.
- `ctrl_in` in CTRL_W: control bits to capture.
- `clear_ovr` in 1: clears `overrun`.
- `ready` out 1: frame is accepted this cycle if `bus_valid` is high.
- `pin_out` out PIN_W: current slot data, registered.
- `phase_out` out PH_W: index of the slot on `pin_out`, registered.
- `busy` out 1: a frame slot is on `pin_out`.
- `frame_done` out 1: one-cycle pulse during the last slot of each frame.
- `overrun` out 1: sticky; a strobe was dropped.
- `parity_out` out 1: present only with `Z80_PIN_MUX_PARITY_EN`.

## Operation
- Frame format: `{zero pad, ctrl_in, addr_in}`, `NPH*PIN_W` bits wide. Slot k is `frame[k*PIN_W +: PIN_W]`.
  - Default mapping: slot0 = A[7:0], slot1 = A[15:8], slot2 = ctrl.
- Accept condition: `bus_valid && ready`. Frame is captured at the clock edge.
- `ready` is combinational: `!busy || (phase_out == NPH-1)`. This allows back-to-back frames with no gap.
- State: IDLE or SEND(phase).
  - IDLE on accept -> SEND(0).
  - SEND(k), k<NPH-1 -> SEND(k+1).
  - SEND(NPH-1) -> SEND(0) on accept, otherwise IDLE.
- IDLE outputs: `busy`=0, `phase_out`=0. `pin_out` holds the last slot driven.
- `bus_valid` while `!ready`: strobe dropped, frame in flight is unaffected, `overrun` set.
- `overrun` precedence: set has priority over `clear_ovr` in the same cycle. `clear_ovr` alone clears it the next cycle.
- `NPH==1`: `ready` is always 1. Every accept produces a single-slot frame with `frame_done` high.

## Timing
- Reset values: `pin_out`=0, `phase_out`=0, `busy`=0, `frame_done`=0, `overrun`=0, `parity_out`=0. `ready` is 1 while in reset.
- Latency: accept at edge T gives slot0 on `pin_out` in cycle T+1 and slot k in cycle T+1+k.
- `frame_done` is high during cycle T+NPH, the same cycle as the last slot.
- Back-to-back: accept in the last-slot cycle puts slot0 of the new frame on the next cycle. `busy` stays 1 throughout.
- Reset mid-frame: asynchronous abort, all outputs to reset values immediately. The partial frame is discarded and no `frame_done` is issued.
- All outputs except `ready` are registered. There is no combinational path from `addr_in`/`ctrl_in` to any output.

## Configuration
- `Z80_PIN_MUX_PARITY_EN` defined:
  - `parity_out` is present and registered alongside `pin_out`.
  - It carries even parity (XOR) of the current slot.
  - In IDLE it is the parity of the held `pin_out` value.
- `Z80_PIN_MUX_PARITY_EN` undefined: `parity_out` port and logic are absent. All other behaviour is identical.

## Test plan
- Reset then single frame: addr 0x1234, ctrl 0xA5 accepted at T -> `pin_out` 0x34, 0x12, 0xA5 at T+1..T+3; `phase_out` 0, 1, 2; `frame_done` high only at T+3; `busy` 0 at T+4 with `pin_out` holding 0xA5.
- Back-to-back: second frame (0xBEEF, 0x01) accepted at T+3 -> 0xEF, 0xBE, 0x01 at T+4..T+6; `busy` never drops.
- Overrun: `bus_valid` at T+1 during a frame -> strobe ignored, `pin_out` sequence unchanged, `overrun`=1 from T+2. `clear_ovr` together with another dropped strobe -> `overrun` stays 1. `clear_ovr` alone -> `overrun`=0 the next cycle.
- Async reset asserted mid-frame at slot1 -> all outputs 0 without waiting for a clock edge, no `frame_done`. After release a new frame starts from slot0.
- Params `ADDR_W`=4, `CTRL_W`=2, `PIN_W`=8 (NPH=1): addr 0xF, ctrl 0x3 -> `pin_out` 0x3F one cycle later with `frame_done`=1; accept on every cycle and `overrun` never set.
- With `Z80_PIN_MUX_PARITY_EN`, frame 0x1234/0xA5 -> `parity_out` 1, 0, 0 across the three slots.

Source files
------------

// File: rtl/z80_pin_mux.sv
// z80_pin_mux
// -----------------------------------------------------------------------------
// Bus-to-pin multiplexer between the Z80 core and the dedicated output pins.
// Each accepted bus strobe captures {ctrl_in, addr_in} as one frame. The frame
// is then emitted over PIN_W pins as NPH consecutive slots, low slot first.
// Slot 0 is placed on pin_out the cycle after the accept. A new frame may be
// accepted during the last slot, so frames can run back-to-back with no gap.
//
// Optional feature macro: Z80_PIN_MUX_PARITY_EN
//   When defined, parity_out carries the registered XOR of pin_out.
//
// Parameters:
//   ADDR_W  address bits per frame
//   CTRL_W  control bits per frame
//   PIN_W   output pin width
//   NPH     (derived) number of slots per frame = ceil((ADDR_W+CTRL_W)/PIN_W)
//   PH_W    (derived) width of phase_out, at least 1
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus_valid  core presents a new bus state this cycle
//   addr_in    address to capture
//   ctrl_in    control bits to capture
//   clear_ovr  clears overrun; a drop in the same cycle wins over the clear
//   ready      combinational: a frame is accepted this cycle if bus_valid
//   pin_out    registered current slot data
//   phase_out  registered index of the slot on pin_out (0 when idle)
//   busy       a frame slot is on pin_out
//   frame_done one-cycle pulse during the last slot of each frame
//   overrun    sticky flag: a strobe arrived while not ready
//   parity_out (Z80_PIN_MUX_PARITY_EN only) XOR of pin_out, registered
// -----------------------------------------------------------------------------
module z80_pin_mux #(
  parameter int ADDR_W = 16,
  parameter int CTRL_W = 8,
  parameter int PIN_W  = 8,
  localparam int NPH   = (ADDR_W + CTRL_W + PIN_W - 1) / PIN_W,
  localparam int PH_W  = (NPH > 1) ? $clog2(NPH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_valid,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              clear_ovr,
  output logic              ready,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PH_W-1:0]   phase_out,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
`ifdef Z80_PIN_MUX_PARITY_EN
  ,
  output logic              parity_out
`endif
);

  localparam int FRAME_W = NPH * PIN_W;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NPH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [PIN_W-1:0]   pin_q, pin_d;
  logic [FRAME_W-1:0] frame_in;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;
  logic               accept;
  logic               drop;

  // Frame layout is {zero pad, ctrl, addr}; the cast zero-extends into the pad.
  assign frame_in = FRAME_W'({ctrl_in, addr_in});

  // busy comes straight from the state flop, so it stays a registered output.
  assign busy      = (state_q == SEND);
  assign ready     = !busy || (phase_q == LAST_PH);
  assign accept    = bus_valid && ready;
  assign drop      = bus_valid && !ready;

  assign pin_out    = pin_q;
  assign phase_out  = phase_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

  // Next-state logic. The remaining slots of the frame in flight live in a
  // right-shifting register, so every step only ever reads its low PIN_W bits.
  // An accept takes priority: it can only happen from IDLE or the last slot,
  // and in both cases slot 0 of the new frame goes straight onto the pins.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pin_d        = pin_q;
    shift_d      = shift_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    if (accept) begin
      state_d = SEND;
      phase_d = '0;
      pin_d   = frame_in[PIN_W-1:0];
      shift_d = frame_in >> PIN_W;
    end else if (state_q == SEND) begin
      if (phase_q == LAST_PH) begin
        // Frame finished with nothing queued: pins keep the last slot.
        state_d = IDLE;
        phase_d = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
        pin_d   = shift_q[PIN_W-1:0];
        shift_d = shift_q >> PIN_W;
      end
    end

    // Registered so that the pulse lines up with the last slot on the pins.
    frame_done_d = (state_d == SEND) && (phase_d == LAST_PH);

    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      pin_q        <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pin_q        <= pin_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef Z80_PIN_MUX_PARITY_EN
  logic parity_q;

  // Parity is computed from the value about to be registered, so it always
  // matches pin_out, including the held value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^pin_d;
    end
  end

  assign parity_out = parity_q;
`endif

endmodule
